// File: rtl/conv_pad_inserter.sv
// +---------------------------------------------------------------------------+
// | conv_pad_inserter: adds a 1-pixel zero border (or passes through) on a     |
// | raster-ordered activation stream. Optional macro: CONV_PAD_LAST_CHECK_EN.  |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module conv_pad_inserter #(
  parameter int DATA_W = 64,
  parameter int DIM_W  = 16,
  parameter int GRP_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIM_W-1:0]  cfg_img_width,
  input  logic [DIM_W-1:0]  cfg_img_height,
  input  logic [GRP_W-1:0]  cfg_ci_groups,
  input  logic              cfg_pad_en,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_out_valid,
  output logic              pixel_out_last,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]  w_q, w_d;
  logic [DIM_W-1:0]  h_q, h_d;
  logic [GRP_W-1:0]  g_q, g_d;
  logic              pad_q, pad_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [DIM_W:0]    col_q, col_d;
  logic [DIM_W:0]    row_q, row_d;
  logic [DATA_W-1:0] pixel_out_q, pixel_out_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic [DIM_W:0]    wp, hp, pad_ext;
  logic              loadable, border, last_grp, last_col, is_last;

  // Padded extents are one bit wider so W or H at full range cannot wrap.
  assign pad_ext  = {{(DIM_W-1){1'b0}}, pad_q, 1'b0};
  assign wp       = {1'b0, w_q} + pad_ext;
  assign hp       = {1'b0, h_q} + pad_ext;
  assign loadable = !valid_q || out_ready;
  assign border   = pad_q && ((row_q == '0) || (row_q == hp - 1'b1) ||
                              (col_q == '0) || (col_q == wp - 1'b1));
  assign last_grp = (grp_q == g_q - 1'b1);
  assign last_col = (col_q == wp - 1'b1);
  assign is_last  = last_grp && last_col && (row_q == hp - 1'b1);

`ifdef CONV_PAD_LAST_CHECK_EN
  logic           err_q, err_d;
  logic           final_interior;
  logic [DIM_W:0] last_int_row, last_int_col;

  assign last_int_row   = pad_q ? hp - 2'd2 : hp - 1'b1;
  assign last_int_col   = pad_q ? wp - 2'd2 : wp - 1'b1;
  assign final_interior = last_grp && (col_q == last_int_col) && (row_q == last_int_row);
  assign err            = err_q;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign err           = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    g_d         = g_q;
    pad_d       = pad_q;
    grp_d       = grp_q;
    col_d       = col_q;
    row_d       = row_q;
    pixel_out_d = pixel_out_q;
    valid_d     = valid_q;
    last_d      = last_q;
`ifdef CONV_PAD_LAST_CHECK_EN
    err_d       = err_q;
`endif

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          w_d   = cfg_img_width;
          h_d   = cfg_img_height;
          g_d   = cfg_ci_groups;
          pad_d = cfg_pad_en;
          grp_d = '0;
          col_d = '0;
          row_d = '0;
`ifdef CONV_PAD_LAST_CHECK_EN
          err_d = 1'b0;
`endif
          if ((cfg_img_width == '0) || (cfg_img_height == '0) || (cfg_ci_groups == '0))
            state_d = ST_FIN;
          else
            state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (loadable && (border || s_valid)) begin
          pixel_out_d = border ? '0 : s_data;
          valid_d     = 1'b1;
          last_d      = is_last;
`ifdef CONV_PAD_LAST_CHECK_EN
          if (!border && (s_last != final_interior))
            err_d = 1'b1;
`endif
          if (last_grp) begin
            grp_d = '0;
            if (last_col) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            grp_d = grp_q + 1'b1;
          end
          if (is_last)
            state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (valid_q && out_ready)
          state_d = ST_FIN;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      g_q         <= '0;
      pad_q       <= 1'b0;
      grp_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pixel_out_q <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      g_q         <= g_d;
      pad_q       <= pad_d;
      grp_q       <= grp_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pixel_out_q <= pixel_out_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

`ifdef CONV_PAD_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end
`endif

  assign busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done            = (state_q == ST_FIN);
  assign s_ready         = (state_q == ST_RUN) && !border && loadable;
  assign pixel_out       = pixel_out_q;
  assign pixel_out_valid = valid_q;
  assign pixel_out_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_pad_inserter.sv
// +---------------------------------------------------------------------------+
// | tb_conv_pad_inserter: randomized self-checking bench for conv_pad_inserter |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_conv_pad_inserter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_img_width, cfg_img_height;
  logic [9:0]  cfg_ci_groups;
  logic        cfg_pad_en, go;
  logic        busy, done, err;
  logic [63:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [63:0] pixel_out;
  logic        pixel_out_valid, pixel_out_last, out_ready;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  conv_pad_inserter dut (
    .clk(clk), .rst(rst),
    .cfg_img_width(cfg_img_width), .cfg_img_height(cfg_img_height),
    .cfg_ci_groups(cfg_ci_groups), .cfg_pad_en(cfg_pad_en), .go(go),
    .busy(busy), .done(done), .err(err),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
    .pixel_out_last(pixel_out_last), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pixel_out"}, pixel_out, 64'd0);
    check({tag, "_valid"}, {63'd0, pixel_out_valid}, 64'd0);
    check({tag, "_last"}, {63'd0, pixel_out_last}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_err"}, {63'd0, err}, 64'd0);
    check({tag, "_s_ready"}, {63'd0, s_ready}, 64'd0);
  endtask

  // Drives one frame and checks it against a raster-order model of the
  // padded image. bad_last >= 0 raises s_last early on that input index;
  // abort_after > 0 stops the frame (without reset) after that many outputs.
  task automatic run_frame(input int w, input int h, input int g, input bit pad,
                           input bit bp, input int bad_last, input int abort_after,
                           input bit go_spam);
    logic [63:0] in_q[$];
    logic [63:0] exp_q[$];
    int hp, wp, n_in, n_out, in_idx, out_cnt, cyc, limit;
    int done_cnt, done_cyc, first_cyc, last_cyc, k;
    bit exp_err;

    hp    = h + 2 * int'(pad);
    wp    = w + 2 * int'(pad);
    n_in  = w * h * g;
    n_out = (n_in == 0) ? 0 : hp * wp * g;
    for (int i = 0; i < n_in; i++) in_q.push_back({$urandom, $urandom});
    k = 0;
    for (int r = 0; r < hp && n_out > 0; r++)
      for (int c = 0; c < wp; c++)
        for (int q = 0; q < g; q++)
          if (pad && (r == 0 || r == hp - 1 || c == 0 || c == wp - 1))
            exp_q.push_back(64'd0);
          else begin
            exp_q.push_back(in_q[k]);
            k++;
          end

    @(negedge clk);
    cfg_img_width  = 16'(w);
    cfg_img_height = 16'(h);
    cfg_ci_groups  = 10'(g);
    cfg_pad_en     = pad;
    go             = 1'b1;
    s_valid        = 1'b0;
    out_ready      = 1'b1;

    in_idx = 0; out_cnt = 0; done_cnt = 0; done_cyc = -1;
    first_cyc = -1; last_cyc = -1; cyc = 1;
    limit = n_out * 8 + 50;
    @(negedge clk);
    check("busy_after_go", {63'd0, busy}, {63'd0, n_out > 0});
    check("err_cleared_by_go", {63'd0, err}, 64'd0);

    while (cyc < limit && done_cnt == 0) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_valid   = (in_idx < n_in) && (bp ? ($urandom_range(0, 2) != 0) : 1'b1);
      s_data    = (in_idx < n_in) ? in_q[in_idx] : 64'd0;
      s_last    = (in_idx == n_in - 1) || (in_idx == bad_last);
      go        = go_spam && ($urandom_range(0, 3) == 0);
      if (go_spam) begin
        cfg_img_width  = 16'($urandom_range(1, 9));
        cfg_img_height = 16'($urandom_range(1, 9));
        cfg_ci_groups  = 10'($urandom_range(1, 3));
        cfg_pad_en     = 1'($urandom);
      end
      #1;
      if (!pad && !bp && in_idx < n_in)
        check("passthru_s_ready", {63'd0, s_ready}, 64'd1);
      if (pixel_out_valid && out_ready) begin
        if (out_cnt < n_out) begin
          check($sformatf("beat%0d_data", out_cnt), pixel_out, exp_q[out_cnt]);
          check($sformatf("beat%0d_last", out_cnt), {63'd0, pixel_out_last},
                {63'd0, out_cnt == n_out - 1});
        end else begin
          check("extra_beat", 64'(out_cnt), 64'(n_out - 1));
        end
        if (out_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
      end
      if (s_valid && s_ready) in_idx++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (abort_after > 0 && out_cnt >= abort_after) break;
      @(negedge clk);
      cyc++;
    end
    go = 1'b0;
    if (abort_after > 0) return;

    check("frame_timeout", {63'd0, cyc >= limit}, 64'd0);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("out_beats", 64'(out_cnt), 64'(n_out));
    check("in_beats", 64'(in_idx), 64'(n_in));
    check("done_count", 64'(done_cnt), 64'd1);
`ifdef CONV_PAD_LAST_CHECK_EN
    exp_err = (bad_last >= 0);
`else
    exp_err = 1'b0;
`endif
    check("err_flag", {63'd0, err}, {63'd0, exp_err});
    if (n_out > 0) begin
      check("done_after_last_hs", 64'(done_cyc), 64'(last_cyc + 1));
      if (!bp) begin
        check("first_beat_latency", 64'(first_cyc), 64'd2);
        check("frame_cycles", 64'(last_cyc - first_cyc + 1), 64'(n_out));
      end
    end else begin
      check("empty_frame_done_cycle", 64'(done_cyc), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    out_ready = 1'b1; cfg_img_width = '0; cfg_img_height = '0;
    cfg_ci_groups = '0; cfg_pad_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    run_frame(8, 8, 1, 1'b1, 1'b0, -1, 0, 1'b0);   // basic padded
    run_frame(2, 2, 2, 1'b1, 1'b0, -1, 0, 1'b0);   // channel groups
    run_frame(4, 4, 1, 1'b0, 1'b0, -1, 0, 1'b0);   // pass-through
    run_frame(8, 8, 1, 1'b1, 1'b1, -1, 0, 1'b0);   // backpressure + gaps
    run_frame(3, 5, 3, 1'b0, 1'b1, -1, 0, 1'b0);   // unpadded, gapped
    run_frame(8, 8, 1, 1'b1, 1'b0, 10, 0, 1'b0);   // early s_last
    run_frame(3, 2, 1, 1'b1, 1'b0, -1, 0, 1'b0);   // err must clear on go
    run_frame(0, 4, 1, 1'b1, 1'b0, -1, 0, 1'b0);   // zero width

    run_frame(8, 8, 1, 1'b1, 1'b0, -1, 40, 1'b0);  // abandoned by reset
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("midframe_reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("no_done_after_reset", {63'd0, done}, 64'd0);
    end

    run_frame(8, 8, 1, 1'b1, 1'b1, -1, 0, 1'b1);   // go spam while busy

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/conv_pad_inserter.md
# conv_pad_inserter

Upstream feeder for `conv_top`: accepts an unpadded, raster-ordered activation stream (64-bit beats, 8 int8 channels per beat, channel groups innermost) and emits the zero-padded stream `conv_top` expects on `pixel_in`/`pixel_in_valid`/`pixel_in_last`. It inserts a 1-pixel zero border for 3x3 layers, or passes data through unpadded for 1x1 layers. This removes host-side padding, so DDR holds only unpadded feature maps.

## Interface
- `DATA_W`, 64: beat width (8 channels x int8).
- `DIM_W`, 16: width of the image dimension fields.
- `GRP_W`, 10: width of the channel-group count.
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `cfg_img_width` input DIM_W: unpadded width W; latched on `go`.
- `cfg_img_height` input DIM_W: unpadded height H; latched on `go`.
- `cfg_ci_groups` input GRP_W: input channel groups G (beats per pixel); latched on `go`.
- `cfg_pad_en` input 1: 1 = add a 1-pixel zero border, 0 = pass-through; latched on `go`.
- `go` input 1: start-of-frame pulse; ignored while `busy`.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse at end of frame.
- `err` output 1: sticky input-framing error (see Configuration).
- `s_data` input DATA_W: unpadded input beat.
- `s_valid` input 1: input beat valid.
- `s_last` input 1: marks the final input beat of the frame.
- `s_ready` output 1: input beat accepted when `s_valid && s_ready`.
- `pixel_out` output DATA_W: padded beat, connects to `conv_top.pixel_in`.
- `pixel_out_valid` output 1: output beat valid.
- `pixel_out_last` output 1: marks the final padded beat.
- `out_ready` input 1: downstream accept; tied high when driving `conv_top`.

## Operation
- **Padded dimensions:** Wp = W + 2·pad and Hp = H + 2·pad. Total output beats = Hp·Wp·G.
- **Counters:** `grp` (0..G-1, innermost), `col` (0..Wp-1), `row` (0..Hp-1). All three advance on each output beat generated.
- **Border beat:** with pad enabled, a beat is a border beat when row==0, row==Hp-1, col==0 or col==Wp-1. Border beats output zero and consume no input.
- **Interior beat:** every non-border beat requires an input beat. `s_data` is copied unchanged to the output.
- **FSM:**
  - IDLE: on `go`, latch cfg, clear counters, go to RUN. If W==0, H==0 or G==0, go to FIN instead.
  - RUN: generate beats. When the last beat is loaded into the output register, go to DRAIN.
  - DRAIN: wait for that last beat to be accepted, then go to FIN.
  - FIN: pulse `done`, return to IDLE.
- **Output register:** loads when `!pixel_out_valid || out_ready`.
- **Input ready:** `s_ready` = RUN && current beat is interior && output register loadable.
- **Input starvation:** if an interior beat is due and `s_valid` is low, generation stalls. Border beats never wait on input.
- `pixel_out_last` is asserted only with the final beat (row=Hp-1, col=Wp-1, grp=G-1).
- `err` clears on `go` and on `rst`.

## Timing
- **Reset values:** `busy`=0, `done`=0, `err`=0, `s_ready`=0, `pixel_out`=0, `pixel_out_valid`=0, `pixel_out_last`=0. FSM returns to IDLE.
- **Reset mid-frame:** counters and output are abandoned with no `done`. The next frame requires a new `go`.
- **Start:** `busy` rises the cycle after `go`. The first output beat is valid 2 cycles after `go`.
- **Latency:** 1 cycle from input acceptance to output valid.
- **Throughput:** 1 beat per cycle with `out_ready`=1 and `s_valid` held high. An unstalled frame takes Hp·Wp·G cycles from the first beat.
- **End of frame:** `done` pulses 1 cycle after the last beat's handshake. `busy` is low in the `done` cycle.
- **`go` while busy:** ignored, with no effect on the counters or on `err`.
- **cfg changes mid-frame:** no effect, because cfg is latched on `go`.

## Configuration
- **`CONV_PAD_LAST_CHECK_EN` defined:** input framing is checked and `err` is set on either of:
  - `s_last`=1 on an interior beat other than the final one;
  - `s_last`=0 on the final interior beat.

  The beat is still consumed and the frame completes normally.
- **`CONV_PAD_LAST_CHECK_EN` undefined:** `s_last` is ignored, `err` is tied 0, and no check logic is built.

## Test plan
- **Basic padded frame:** W=H=8, G=1, pad=1, `out_ready`=1, 64 input beats. Require:
  - 100 output beats;
  - beats on row 0, row 9, col 0 and col 9 are zero;
  - interior beat (r,c) = input[(r-1)·8+(c-1)];
  - `pixel_out_last` only on beat 99;
  - a single `done`;
  - the output matches the `conv_top` layer-0 padded stimulus.
- **Multiple channel groups:** W=H=2, G=2, pad=1. Require:
  - 32 output beats;
  - beats 0–9 are zero;
  - beats 10,11 = in0,in1 and beats 12,13 = in2,in3;
  - last on beat 31.
- **Pass-through:** pad=0, W=H=4, G=1. Require the 16 output beats to equal the input, and `s_ready` high every cycle.
- **Backpressure and starvation:** case 1 with `out_ready` toggling pseudo-randomly and `s_valid` gapped. Require an identical 100-beat sequence with no drops or duplicates, and border beats still emitted during input gaps.
- **Framing check (macro defined):** `s_last` asserted on input beat 10 of 64. Require `err`=1 sticky, 100 beats still output, and `err` cleared by the next `go`.
- **Reset and `go` robustness:** assert `rst` after 40 beats. Require all outputs 0 the next cycle and no `done`. A new `go` then yields a full correct 100-beat frame, and `go` pulses issued during that frame are ignored.
